// File: rtl/hx8357_pkg.sv
// Shared HX8357 definitions: arbiter states, bus width, DCS opcodes.
// Used by the bus arbiter and the init/config sequencer.
package hx8357_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_CMPL,
    HOLD
  } arb_state_e;

  localparam logic [7:0] DCS_SLPOUT = 8'h11;
  localparam logic [7:0] DCS_DISPON = 8'h29;
  localparam logic [7:0] DCS_CASET  = 8'h2A;
  localparam logic [7:0] DCS_PASET  = 8'h2B;
  localparam logic [7:0] DCS_RAMWR  = 8'h2C;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hx8357_bus_arbiter_if.sv
// Requester-side packet handshake plus the single HX8357 writer port.
// master: arbiter view; slave: requesters/writer view.
interface hx8357_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int WORD_W = 16
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_is_cmd;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*WORD_W-1:0] req_word;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic                    transmission_cmpl;
  logic [WORD_W-1:0]       data_lines;
  logic                    cmd;
  logic                    data;

  modport master (
    input  req_valid, req_is_cmd, req_last,
    input  req_word, transmission_cmpl,
    output req_ready, grant, data_lines,
    output cmd, data
  );

  modport slave (
    output req_valid, req_is_cmd, req_last,
    output req_word, transmission_cmpl,
    input  req_ready, grant, data_lines,
    input  cmd, data
  );

endinterface

// File: rtl/hx8357_arb_picker.sv
// One-hot winner search over req_valid, starting at index ptr.
// With ptr held at 0 this is plain lowest-index-wins priority.
module hx8357_arb_picker
  import hx8357_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        win
);

  localparam int PW = idx_w(N_REQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hx8357_bus_arbiter.sv
// Packet-locked arbiter sharing the HX8357 writer between requesters.
// Define HX8357_ARB_RR_EN for round-robin instead of fixed priority.
module hx8357_bus_arbiter #(
  parameter int N_REQ        = 2,
  parameter int HOLD_TIMEOUT = 255,
  parameter int WORD_W       = 16
) (
  input  logic                 clk,
  input  logic                 nres,
  hx8357_bus_arbiter_if.master bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 hold_to_err
);

  import hx8357_pkg::*;

  localparam int PW = idx_w(N_REQ);
  localparam int CW =
    (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_d, win;
  logic [WORD_W-1:0] dl_d;
  logic              cmd_d, data_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_d, fire;
  logic [PW-1:0]     g_idx, ptr;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (bus.grant[i]) g_idx = PW'(i);
  end

  hx8357_arb_picker #(.N_REQ(N_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .win       (win)
  );

`ifdef HX8357_ARB_RR_EN
  logic [PW-1:0] ptr_q;
  logic          done;

  assign done = fire ||
    (state_q == WAIT_CMPL && bus.transmission_cmpl && last_q);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres)
      ptr_q <= '0;
    else if (done)
      ptr_q <= PW'((int'(g_idx) + 1) % N_REQ);
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = bus.grant;
    dl_d          = bus.data_lines;
    cmd_d         = 1'b0;
    data_d        = 1'b0;
    last_d        = last_q;
    cnt_d         = cnt_q;
    fire          = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.req_ready = bus.grant;
        dl_d    = bus.req_word[g_idx*WORD_W +: WORD_W];
        cmd_d   = bus.req_is_cmd[g_idx];
        data_d  = ~bus.req_is_cmd[g_idx];
        last_d  = bus.req_last[g_idx];
        state_d = WAIT_CMPL;
      end
      WAIT_CMPL: begin
        if (bus.transmission_cmpl) begin
          if (last_q) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.req_valid[g_idx]) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (HOLD_TIMEOUT != 0 &&
              cnt_d == CW'(HOLD_TIMEOUT)) begin
            fire    = 1'b1;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a watchdog firing outranks a same-cycle clear
  assign err_d = fire | (hold_to_err & ~err_clr);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q        <= IDLE;
      bus.grant      <= '0;
      bus.data_lines <= '0;
      bus.cmd        <= 1'b0;
      bus.data       <= 1'b0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
      hold_to_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.grant      <= grant_d;
      bus.data_lines <= dl_d;
      bus.cmd        <= cmd_d;
      bus.data       <= data_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      hold_to_err    <= err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_hx8357_bus_arbiter.sv
// Directed vector table plus hand sequences for hx8357_bus_arbiter.
// Instance uses HOLD_TIMEOUT=4 so the watchdog is reachable quickly.
module tb_hx8357_bus_arbiter;

  typedef struct {
    logic [1:0]  v, c, l;
    logic [15:0] w0, w1;
    logic        cmpl;
    logic [1:0]  eg, er;
    logic        ecmd, edat;
    logic [15:0] edl;
    logic        ebusy;
  } vec_t;

  logic clk, nres, err_clr, busy, hold_to_err;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv[$];

  hx8357_bus_arbiter_if #(.N_REQ(2), .WORD_W(16)) bus();

  hx8357_bus_arbiter #(
    .N_REQ(2), .HOLD_TIMEOUT(4), .WORD_W(16)
  ) dut (
    .clk         (clk),
    .nres        (nres),
    .bus         (bus),
    .err_clr     (err_clr),
    .busy        (busy),
    .hold_to_err (hold_to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] v, c, l,
    input logic [15:0] w0, w1,
    input logic cmpl,
    input logic [1:0] eg, er,
    input logic ecmd, edat,
    input logic [15:0] edl,
    input logic ebusy);
    vec_t r;
    r.v = v; r.c = c; r.l = l;
    r.w0 = w0; r.w1 = w1; r.cmpl = cmpl;
    r.eg = eg; r.er = er;
    r.ecmd = ecmd; r.edat = edat;
    r.edl = edl; r.ebusy = ebusy;
    return r;
  endfunction

  task automatic issue(input int idx,
                       input logic c,
                       input logic l,
                       input logic [15:0] w,
                       input logic [1:0] eg);
    logic got;
    got = 1'b0;
    bus.req_valid[idx]        = 1'b1;
    bus.req_is_cmd[idx]       = c;
    bus.req_last[idx]         = l;
    bus.req_word[idx*16 +: 16] = w;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = bus.req_ready[idx];
    end
    chk("issue.ready", 32'(got), 32'd1);
    chk("issue.grant", 32'(bus.grant), 32'(eg));
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    @(negedge clk);
    chk("issue.cmd", 32'(bus.cmd), 32'(c));
    chk("issue.data", 32'(bus.data), 32'(!c));
    chk("issue.dl", 32'(bus.data_lines), 32'(w));
    @(posedge clk); #1;
    bus.transmission_cmpl = 1'b1;
    @(posedge clk); #1;
    bus.transmission_cmpl = 1'b0;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = |bus.req_ready;
    end
  endtask

  initial begin
    logic       ok;
    logic [1:0] eg;

    // Test 1: single-word command from req0
    tv.push_back(mk(2'b01,2'b01,2'b01,16'h0011,16'h0,0,
                    2'b00,2'b00,0,0,16'h0000,0));
    tv.push_back(mk(2'b01,2'b01,2'b01,16'h0011,16'h0,0,
                    2'b01,2'b01,0,0,16'h0000,1));
    tv.push_back(mk(2'b00,2'b00,2'b00,16'h0,16'h0,0,
                    2'b01,2'b00,1,0,16'h0011,1));
    tv.push_back(mk(2'b00,2'b00,2'b00,16'h0,16'h0,1,
                    2'b01,2'b00,0,0,16'h0011,1));
    tv.push_back(mk(2'b00,2'b00,2'b00,16'h0,16'h0,0,
                    2'b00,2'b00,0,0,16'h0011,0));
`ifndef HX8357_ARB_RR_EN
    // Test 2: both valid, req0 packet 2A/00/3F wins
    tv.push_back(mk(2'b11,2'b01,2'b10,16'h002A,16'h1234,0,
                    2'b00,2'b00,0,0,16'h0011,0));
    tv.push_back(mk(2'b11,2'b01,2'b10,16'h002A,16'h1234,1,
                    2'b01,2'b01,0,0,16'h0011,1));
    tv.push_back(mk(2'b11,2'b00,2'b10,16'h0000,16'h1234,0,
                    2'b01,2'b00,1,0,16'h002A,1));
    tv.push_back(mk(2'b11,2'b00,2'b10,16'h0000,16'h1234,1,
                    2'b01,2'b00,0,0,16'h002A,1));
    tv.push_back(mk(2'b11,2'b00,2'b10,16'h0000,16'h1234,0,
                    2'b01,2'b00,0,0,16'h002A,1));
    tv.push_back(mk(2'b11,2'b00,2'b10,16'h0000,16'h1234,0,
                    2'b01,2'b01,0,0,16'h002A,1));
    tv.push_back(mk(2'b11,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b01,2'b00,0,1,16'h0000,1));
    tv.push_back(mk(2'b11,2'b00,2'b11,16'h003F,16'h1234,1,
                    2'b01,2'b00,0,0,16'h0000,1));
    tv.push_back(mk(2'b11,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b01,2'b00,0,0,16'h0000,1));
    tv.push_back(mk(2'b11,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b01,2'b01,0,0,16'h0000,1));
    tv.push_back(mk(2'b10,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b01,2'b00,0,1,16'h003F,1));
    tv.push_back(mk(2'b10,2'b00,2'b11,16'h003F,16'h1234,1,
                    2'b01,2'b00,0,0,16'h003F,1));
    tv.push_back(mk(2'b10,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b00,2'b00,0,0,16'h003F,0));
    tv.push_back(mk(2'b10,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b10,2'b10,0,0,16'h003F,1));
    tv.push_back(mk(2'b00,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b10,2'b00,0,1,16'h1234,1));
    tv.push_back(mk(2'b00,2'b00,2'b11,16'h003F,16'h1234,1,
                    2'b10,2'b00,0,0,16'h1234,1));
    tv.push_back(mk(2'b00,2'b00,2'b11,16'h003F,16'h1234,0,
                    2'b00,2'b00,0,0,16'h1234,0));
`endif

    nres = 1'b0;
    err_clr = 1'b0;
    bus.req_valid = '0;
    bus.req_is_cmd = '0;
    bus.req_last = '0;
    bus.req_word = '0;
    bus.transmission_cmpl = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.grant", 32'(bus.grant), 32'd0);
    chk("rst.dl", 32'(bus.data_lines), 32'd0);
    chk("rst.cmd", 32'(bus.cmd), 32'd0);
    chk("rst.data", 32'(bus.data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(hold_to_err), 32'd0);
    chk("rst.ready", 32'(bus.req_ready), 32'd0);
    nres = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      bus.req_valid = tv[i].v;
      bus.req_is_cmd = tv[i].c;
      bus.req_last = tv[i].l;
      bus.req_word = {tv[i].w1, tv[i].w0};
      bus.transmission_cmpl = tv[i].cmpl;
      @(negedge clk);
      chk($sformatf("r%0d.grant", i),
          32'(bus.grant), 32'(tv[i].eg));
      chk($sformatf("r%0d.ready", i),
          32'(bus.req_ready), 32'(tv[i].er));
      chk($sformatf("r%0d.cmd", i),
          32'(bus.cmd), 32'(tv[i].ecmd));
      chk($sformatf("r%0d.data", i),
          32'(bus.data), 32'(tv[i].edat));
      chk($sformatf("r%0d.dl", i),
          32'(bus.data_lines), 32'(tv[i].edl));
      chk($sformatf("r%0d.busy", i),
          32'(busy), 32'(tv[i].ebusy));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.transmission_cmpl = 1'b0;

    // Test 3: req0 arrives mid-packet of req1
    issue(1, 1'b0, 1'b0, 16'hA000, 2'b10);
    bus.req_valid[0] = 1'b1;
    bus.req_is_cmd[0] = 1'b1;
    bus.req_last[0] = 1'b1;
    bus.req_word[15:0] = 16'h0055;
    issue(1, 1'b0, 1'b0, 16'hA001, 2'b10);
    issue(1, 1'b0, 1'b0, 16'hA002, 2'b10);
    issue(1, 1'b0, 1'b1, 16'hA003, 2'b10);
    issue(0, 1'b1, 1'b1, 16'h0055, 2'b01);

    // Test 4: stall inside a packet trips the watchdog
    issue(0, 1'b1, 1'b0, 16'h002C, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.busy", k), 32'(busy), 32'd1);
      chk($sformatf("hold%0d.err", k),
          32'(hold_to_err), 32'd0);
    end
    @(negedge clk);
    chk("to.err", 32'(hold_to_err), 32'd1);
    chk("to.grant", 32'(bus.grant), 32'd0);
    chk("to.busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("to.sticky", 32'(hold_to_err), 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr.err", 32'(hold_to_err), 32'd0);

    // Test 5: both requesters stream 1-word packets
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.req_is_cmd = 2'b00;
    bus.req_last = 2'b11;
    bus.req_word = {16'hC001, 16'hC000};
    for (int k = 0; k < 4; k++) begin
`ifdef HX8357_ARB_RR_EN
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
      wait_ready(ok);
      chk($sformatf("p%0d.ready", k), 32'(ok), 32'd1);
      chk($sformatf("p%0d.grant", k),
          32'(bus.grant), 32'(eg));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("p%0d.dl", k), 32'(bus.data_lines),
          (eg == 2'b01) ? 32'hC000 : 32'hC001);
      @(posedge clk); #1;
      bus.transmission_cmpl = 1'b1;
      @(posedge clk); #1;
      bus.transmission_cmpl = 1'b0;
    end
    bus.req_valid = '0;

    // Test 6: asynchronous reset while in WAIT_CMPL
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1;
    bus.req_is_cmd[0] = 1'b1;
    bus.req_last[0] = 1'b1;
    bus.req_word[15:0] = 16'h0029;
    wait_ready(ok);
    chk("ar.ready", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    #1;
    chk("ar.pre_cmd", 32'(bus.cmd), 32'd1);
    nres = 1'b0;
    #1;
    chk("ar.grant", 32'(bus.grant), 32'd0);
    chk("ar.cmd", 32'(bus.cmd), 32'd0);
    chk("ar.data", 32'(bus.data), 32'd0);
    chk("ar.dl", 32'(bus.data_lines), 32'd0);
    chk("ar.busy", 32'(busy), 32'd0);
    chk("ar.err", 32'(hold_to_err), 32'd0);
    @(negedge clk);
    nres = 1'b1;
    issue(0, 1'b0, 1'b1, 16'h0077, 2'b01);
    @(negedge clk);
    chk("ar.idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
